// File: rtl/queue.sv
// queue: take-a-number controller counting issued and served tickets,
// saturating at CAPACITY with a sticky Full flag.
module queue #(
    parameter int WIDTH    = 8,
    parameter int CAPACITY = 100
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             New,
    input  logic             Done,
    output logic [WIDTH-1:0] Current_Client,
    output logic [WIDTH-1:0] Total_Clients,
    output logic             Full
);
    localparam logic [WIDTH-1:0] CAP = CAPACITY[WIDTH-1:0];
    logic             new_prev_q, done_prev_q, full_q;
    logic [WIDTH-1:0] total_q, total_d, curr_q, curr_d;
    logic             new_ev, done_ev;
    always_comb begin
        new_ev  = New & ~new_prev_q;
        done_ev = Done & ~done_prev_q;
        // both guards use pre-update values, so simultaneous events are independent
        total_d = (new_ev && total_q < CAP) ? total_q + 1'b1 : total_q;
        curr_d  = (done_ev && curr_q < total_q) ? curr_q + 1'b1 : curr_q;
    end
    always_ff @(posedge Clk) begin
        new_prev_q  <= New;
        done_prev_q <= Done;
        if (Reset) begin
            total_q <= '0;
            curr_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            total_q <= total_d;
            curr_q  <= curr_d;
            full_q  <= (total_d == CAP);
        end
    end
    assign Current_Client = curr_q;
    assign Total_Clients  = total_q;
    assign Full           = full_q;
endmodule

// File: tb/tb_queue.sv
// tb_queue: directed plus random stimulus against a ticket-count model.
module tb_queue;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1, New = 1'b0, Done = 1'b0;
    logic [7:0] Current_Client, Total_Clients;
    logic       Full;
    int total_chk = 0, bad = 0;
    int m_tot = 0, m_cur = 0, m_full = 0, m_pn = 0, m_pd = 0;

    queue #(.WIDTH(8), .CAPACITY(100)) dut (
        .Clk(Clk), .Reset(Reset), .New(New), .Done(Done),
        .Current_Client(Current_Client), .Total_Clients(Total_Clients), .Full(Full)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        total_chk++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit n, input bit d);
        bit ne, de;
        int t0, c0;
        Reset = r; New = n; Done = d;
        @(posedge Clk);
        ne = n && !m_pn;
        de = d && !m_pd;
        m_pn = n; m_pd = d;
        if (r) begin
            m_tot = 0; m_cur = 0; m_full = 0;
        end else begin
            t0 = m_tot; c0 = m_cur;
            if (ne && t0 < 100) m_tot = t0 + 1;
            if (de && c0 < t0) m_cur = c0 + 1;
            m_full = (m_tot == 100);
        end
        #1;
        chk("total", Total_Clients, m_tot);
        chk("current", Current_Client, m_cur);
        chk("full", Full, m_full);
        chk("invariant", (Current_Client <= Total_Clients && Total_Clients <= 100), 1);
    endtask

    task automatic pulse(input bit n, input bit d);
        step(0, n, d); step(0, n, d); step(0, 0, 0); step(0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0); step(1, 0, 0);
        chk("reset_total", Total_Clients, 0);
        chk("reset_current", Current_Client, 0);
        chk("reset_full", Full, 0);
        for (int i = 0; i < 102; i++) begin
            pulse(1, 0);
            if (i == 98) chk("not_full_at_99", Full, 0);
        end
        chk("fill_total", Total_Clients, 100);
        chk("fill_full", Full, 1);
        chk("fill_current", Current_Client, 0);
        for (int i = 0; i < 102; i++) pulse(0, 1);
        chk("drain_current", Current_Client, 100);
        chk("drain_total", Total_Clients, 100);
        chk("drain_full", Full, 1);
        step(1, 0, 0);
        chk("rst_total", Total_Clients, 0);
        chk("rst_current", Current_Client, 0);
        chk("rst_full", Full, 0);
        step(0, 0, 0);
        for (int i = 0; i < 3; i++) pulse(1, 0);
        for (int i = 0; i < 3; i++) pulse(0, 1);
        pulse(0, 1);
        chk("empty_done_current", Current_Client, 3);
        chk("empty_done_total", Total_Clients, 3);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        step(0, 0, 0);
        chk("hold_new_total", Total_Clients, 4);
        step(1, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 5; i++) pulse(1, 0);
        for (int i = 0; i < 2; i++) pulse(0, 1);
        step(0, 1, 1);
        chk("simul_total", Total_Clients, 6);
        chk("simul_current", Current_Client, 3);
        step(0, 0, 0);
        step(1, 0, 0); step(0, 0, 0);
        step(0, 1, 1);
        chk("simul_empty_total", Total_Clients, 1);
        chk("simul_empty_current", Current_Client, 0);
        step(0, 0, 0);
        step(1, 1, 0); step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        chk("rst_held_new_total", Total_Clients, 0);
        step(0, 0, 0);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
        $display("test done: total=%0d bad=%0d", total_chk, bad);
        $finish;
    end
endmodule
